frame_marker_checker: RTL and testbench
=======================================

Name: frame_marker_checker

Overview:
- Receive-side checker for the processed VGA pixel stream.
- Counts pixels to recover row/col and verifies each frame's fixed overlay:
  - red top-left marker, green top-right marker, blue bottom-left marker;
  - black fill outside the camera window.
- Sits on the output of the RGB processing stage, before the VGA DAC. Used for on-board self-test and for simulation scoreboarding.
- Publishes per-frame pass/fail flags and running frame/error counters.

Parameters:
H_ACTIVE, 640, active pixels per line
V_ACTIVE, 480, active lines per frame
CAM_W, 617, camera window width; cols >= CAM_W must be black
CAM_H, 478, camera window height; rows >= CAM_H must be black
CNT_W, 16, width of frame and error counters

Ports:
iCLK  in  1  pixel clock
iRST  in  1  synchronous active-high reset
i_sof  in  1  start of frame; qualifies the pixel with i_valid=1 on the same cycle as pixel (0,0)
i_valid  in  1  pixel valid (low during blanking and gaps)
i_VGA_R  in  8  pixel red
i_VGA_G  in  8  pixel green
i_VGA_B  in  8  pixel blue
o_frame_done  out  1  one-cycle pulse when a frame's result is published
o_frame_ok  out  1  last published frame passed all checks
o_err_flags  out  5  last frame flags: [0] red, [1] green, [2] blue, [3] black, [4] length
o_frame_cnt  out  CNT_W  frames published, saturating
o_err_cnt  out  CNT_W  frames published with ok=0, saturating
o_first_err_row  out  13  see Optional Feature
o_first_err_col  out  13  see Optional Feature

Behaviour:
- Reset: all outputs 0, state IDLE, row/col counters 0, working flags 0. Reset mid-frame discards that frame; nothing is published.
- States:
  - IDLE: ignore i_valid until i_sof & i_valid, then go to ACTIVE. The pixel on that cycle is (0,0).
  - ACTIVE: each i_valid pixel is checked at the current (row,col). Then col increments; at H_ACTIVE-1, col wraps to 0 and row increments.
  - DONE: entered after pixel (V_ACTIVE-1, H_ACTIVE-1) is accepted. For exactly one cycle: assert o_frame_done, load o_frame_ok / o_err_flags from the working flags, update the counters. Then return to IDLE.
- i_sof is ignored without i_valid. i_valid=0 cycles freeze the counters.
- Check windows (row, col):
  - Red: rows 0-4, cols 0-4. Pixel must equal FF/00/00, else set flag[0].
  - Green: rows 0-4, cols CAM_W-4 .. CAM_W-1. Pixel must equal 00/FF/00, else set flag[1].
  - Blue: rows CAM_H-4 .. CAM_H-1, cols 0-4. Pixel must equal 00/00/FF, else set flag[2].
  - Black: row >= CAM_H or col >= CAM_W, excluding the marker windows above. Pixel must equal 00/00/00, else set flag[3].
  - Marker windows take priority over the black check.
  - All other pixels are camera data and are not checked.
- Working flags are sticky within a frame and cleared on frame start.
- Premature frame start:
  - i_sof & i_valid in ACTIVE at any position other than the natural (0,0) means a short frame.
  - On that cycle, publish the current frame as in DONE with flag[4]=1 (o_frame_done pulses the next cycle).
  - The same cycle also starts a new frame, and the sof pixel is checked as (0,0) of the new frame. No DONE state is used for the short frame.
- Result latency: o_frame_done is high the cycle after the final (or terminating) pixel.
- o_frame_ok = (flags == 0). Outputs hold until the next publish.
- Counters saturate at all-ones. o_err_cnt increments only when ok=0.
- Row/col counters are 13 bits, compared unsigned.

Optional Feature:
- Macro: FMC_FIRST_ERR_CAPTURE_EN.
- Defined:
  - Latch the row/col of the first failing pixel of the frame.
  - Publish it on o_first_err_row/col together with o_frame_done.
  - A length-only failure publishes the row/col at which the premature sof arrived.
  - A clean frame publishes 0/0.
- Undefined: both ports are constant 0 and no capture registers exist.

Test Plan:
- Clean 640x480 frame, correct markers, black fill, random camera pixels, continuous valid -> o_frame_done pulses 1 cycle after pixel 307200; ok=1; flags=00000; frame_cnt=1; err_cnt=0.
- Same frame with pixel (2,2)=FF/01/00 -> flags=00001, ok=0, err_cnt=1. With FIRST_ERR enabled, first_err_row/col=2/2.
- Pixel (479,639)=00/00/01, plus green pixel (4,616)=00/FE/00 -> flags=01010. FIRST_ERR reports row/col 4/616.
- Second sof after 1000 valid pixels -> done with flags[4]=1, ok=0. Following full clean frame -> ok=1, frame_cnt=2, err_cnt=1.
- Clean frame with random i_valid gaps (about 30% low) and i_sof without i_valid before the real start -> identical result to the continuous-valid clean frame; stray sof is ignored.
- iRST pulsed at pixel 150000, then a clean frame -> no done pulse for the aborted frame; next frame ok=1, frame_cnt=1.

Source files
------------

// File: rtl/frame_marker_checker.sv
// frame_marker_checker: receive-side checker for the processed VGA pixel stream.
// Recovers row/col by counting valid pixels from start of frame, checks the fixed
// overlay (red/green/blue corner markers, black fill outside the camera window),
// and publishes per-frame pass/fail flags plus saturating frame/error counters.
// Optional feature macro FMC_FIRST_ERR_CAPTURE_EN: when defined, the row/col of
// the first failing pixel of each frame is reported on o_first_err_row/col.
module frame_marker_checker #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int CAM_W    = 617,
    parameter int CAM_H    = 478,
    parameter int CNT_W    = 16
) (
    input  logic             iCLK,
    input  logic             iRST,
    input  logic             i_sof,
    input  logic             i_valid,
    input  logic [7:0]       i_VGA_R,
    input  logic [7:0]       i_VGA_G,
    input  logic [7:0]       i_VGA_B,
    output logic             o_frame_done,
    output logic             o_frame_ok,
    output logic [4:0]       o_err_flags,
    output logic [CNT_W-1:0] o_frame_cnt,
    output logic [CNT_W-1:0] o_err_cnt,
    output logic [12:0]      o_first_err_row,
    output logic [12:0]      o_first_err_col
);

    typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;

    localparam logic [12:0] H_LAST     = 13'(H_ACTIVE - 1);
    localparam logic [12:0] V_LAST     = 13'(V_ACTIVE - 1);
    localparam logic [12:0] CAM_W_L    = 13'(CAM_W);
    localparam logic [12:0] CAM_H_L    = 13'(CAM_H);
    localparam logic [12:0] GRN_COL_LO = 13'(CAM_W - 4);
    localparam logic [12:0] BLU_ROW_LO = 13'(CAM_H - 4);
    localparam logic [12:0] MARK_SIZE  = 13'd5;

    state_t      state;
    state_t      next_state;
    logic [12:0] row;
    logic [12:0] col;
    logic [3:0]  flags;

    logic        start;
    logic        short_frame;
    logic        active_pix;
    logic        last_pix;
    logic        publish;
    logic [12:0] chk_row;
    logic [12:0] chk_col;
    logic [23:0] rgb;
    logic        in_red;
    logic        in_green;
    logic        in_blue;
    logic        in_black;
    logic [3:0]  pix_err;
    logic [4:0]  pub_flags;

    // Decode frame events and classify the current pixel against the overlay windows.
    // A sof pixel is always checked as (0,0) of the new frame, even when it also
    // terminates a short frame, so the check position is forced to zero on start.
    // In ACTIVE the counters never sit at (0,0), so any accepted sof there is short.
    always_comb begin
        start       = i_sof & i_valid & ((state == IDLE) | (state == ACTIVE));
        short_frame = i_sof & i_valid & (state == ACTIVE);
        active_pix  = i_valid & ~i_sof & (state == ACTIVE);
        last_pix    = active_pix & (row == V_LAST) & (col == H_LAST);
        publish     = last_pix | short_frame;

        chk_row = start ? 13'd0 : row;
        chk_col = start ? 13'd0 : col;
        rgb     = {i_VGA_R, i_VGA_G, i_VGA_B};

        in_red   = (chk_row < MARK_SIZE) & (chk_col < MARK_SIZE);
        in_green = (chk_row < MARK_SIZE) & (chk_col >= GRN_COL_LO) & (chk_col < CAM_W_L);
        in_blue  = (chk_row >= BLU_ROW_LO) & (chk_row < CAM_H_L) & (chk_col < MARK_SIZE);
        in_black = ((chk_row >= CAM_H_L) | (chk_col >= CAM_W_L))
                   & ~(in_red | in_green | in_blue);

        pix_err[0] = in_red   & (rgb != 24'hFF0000);
        pix_err[1] = in_green & (rgb != 24'h00FF00);
        pix_err[2] = in_blue  & (rgb != 24'h0000FF);
        pix_err[3] = in_black & (rgb != 24'h000000);

        pub_flags = short_frame ? {1'b1, flags} : {1'b0, flags | pix_err};
    end

    // State register for the frame tracking FSM.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: a short frame restarts in place, a complete frame passes through DONE.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = ACTIVE;
            ACTIVE:  if (last_pix) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Pixel position counters and sticky working flags for the frame in progress.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            row   <= 13'd0;
            col   <= 13'd0;
            flags <= 4'd0;
        end else if (start) begin
            row   <= 13'd0;
            col   <= 13'd1;
            flags <= pix_err;
        end else if (active_pix) begin
            flags <= flags | pix_err;
            if (last_pix) begin
                row <= 13'd0;
                col <= 13'd0;
            end else if (col == H_LAST) begin
                row <= row + 13'd1;
                col <= 13'd0;
            end else begin
                col <= col + 13'd1;
            end
        end
    end

    // Publish the frame result, pulse done and bump the saturating counters.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            o_frame_done <= 1'b0;
            o_frame_ok   <= 1'b0;
            o_err_flags  <= 5'd0;
            o_frame_cnt  <= '0;
            o_err_cnt    <= '0;
        end else begin
            o_frame_done <= publish;
            if (publish) begin
                o_frame_ok  <= (pub_flags == 5'd0);
                o_err_flags <= pub_flags;
                if (o_frame_cnt != '1) begin
                    o_frame_cnt <= o_frame_cnt + CNT_W'(1);
                end
                if ((pub_flags != 5'd0) && (o_err_cnt != '1)) begin
                    o_err_cnt <= o_err_cnt + CNT_W'(1);
                end
            end
        end
    end

`ifdef FMC_FIRST_ERR_CAPTURE_EN
    logic [12:0] err_row;
    logic [12:0] err_col;

    // Remember where the first failing pixel of the current frame was seen.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            err_row <= 13'd0;
            err_col <= 13'd0;
        end else if (start) begin
            err_row <= 13'd0;
            err_col <= 13'd0;
        end else if (active_pix && (flags == 4'd0) && (pix_err != 4'd0)) begin
            err_row <= row;
            err_col <= col;
        end
    end

    // Publish the first-failure position alongside the frame result; a length-only
    // failure reports where the premature sof arrived, a clean frame reports 0/0.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            o_first_err_row <= 13'd0;
            o_first_err_col <= 13'd0;
        end else if (publish) begin
            if (flags != 4'd0) begin
                o_first_err_row <= err_row;
                o_first_err_col <= err_col;
            end else if (short_frame || (pix_err != 4'd0)) begin
                o_first_err_row <= row;
                o_first_err_col <= col;
            end else begin
                o_first_err_row <= 13'd0;
                o_first_err_col <= 13'd0;
            end
        end
    end
`else
    assign o_first_err_row = 13'd0;
    assign o_first_err_col = 13'd0;
`endif

endmodule

// File: tb/tb_frame_marker_checker.sv
// tb_frame_marker_checker: self-checking bench for frame_marker_checker.
// Runs a reduced 32x16 frame geometry so many frames fit in a short run.
// Frame cases come from a vector table; expected results are pushed to a
// scoreboard queue as the final/terminating pixel is driven and popped when
// o_frame_done pulses. Hand-written sequences cover reset, hold and saturation.
module tb_frame_marker_checker;

    localparam int HA        = 32;
    localparam int VA        = 16;
    localparam int CW        = 25;
    localparam int CH        = 14;
    localparam int NC        = 4;
    localparam int FRAME_PIX = HA * VA;
    localparam int NVEC      = 15;

    logic          iCLK = 1'b0;
    logic          iRST;
    logic          i_sof;
    logic          i_valid;
    logic [7:0]    i_VGA_R;
    logic [7:0]    i_VGA_G;
    logic [7:0]    i_VGA_B;
    logic          o_frame_done;
    logic          o_frame_ok;
    logic [4:0]    o_err_flags;
    logic [NC-1:0] o_frame_cnt;
    logic [NC-1:0] o_err_cnt;
    logic [12:0]   o_first_err_row;
    logic [12:0]   o_first_err_col;

    frame_marker_checker #(
        .H_ACTIVE(HA),
        .V_ACTIVE(VA),
        .CAM_W(CW),
        .CAM_H(CH),
        .CNT_W(NC)
    ) dut (
        .iCLK(iCLK),
        .iRST(iRST),
        .i_sof(i_sof),
        .i_valid(i_valid),
        .i_VGA_R(i_VGA_R),
        .i_VGA_G(i_VGA_G),
        .i_VGA_B(i_VGA_B),
        .o_frame_done(o_frame_done),
        .o_frame_ok(o_frame_ok),
        .o_err_flags(o_err_flags),
        .o_frame_cnt(o_frame_cnt),
        .o_err_cnt(o_err_cnt),
        .o_first_err_row(o_first_err_row),
        .o_first_err_col(o_first_err_col)
    );

    // Free-running pixel clock.
    always #5 iCLK = ~iCLK;

    int cyc = 0;

    // Cycle counter used to check result latency.
    always @(posedge iCLK) cyc <= cyc + 1;

    typedef struct {
        int          short_len;
        int          gap_pct;
        bit          stray;
        int          b0_row;
        int          b0_col;
        logic [23:0] b0_rgb;
        int          b1_row;
        int          b1_col;
        logic [23:0] b1_rgb;
        logic [4:0]  exp_flags;
        int          exp_row;
        int          exp_col;
    } vec_t;

    typedef struct {
        int            id;
        logic [4:0]    flags;
        logic          ok;
        logic [NC-1:0] fcnt;
        logic [NC-1:0] ecnt;
        logic [12:0]   row;
        logic [12:0]   col;
        int            cyc;
    } exp_t;

    exp_t          sb[$];
    exp_t          mon_e;
    int            n_vec = 0;
    int            n_miss = 0;
    logic [NC-1:0] m_fcnt = '0;
    logic [NC-1:0] m_ecnt = '0;
    logic          m_ok = 1'b0;
    logic [4:0]    m_flags = 5'd0;
    vec_t          pend_vec;
    int            pend_id = 0;
    bit            have_pend = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mkVec(input int sl, input int gap, input bit stray,
                                   input int r0, input int c0, input logic [23:0] p0,
                                   input int r1, input int c1, input logic [23:0] p1,
                                   input logic [4:0] ef, input int er, input int ec);
        vec_t v;
        v.short_len = sl;  v.gap_pct = gap;  v.stray = stray;
        v.b0_row = r0;     v.b0_col = c0;    v.b0_rgb = p0;
        v.b1_row = r1;     v.b1_col = c1;    v.b1_rgb = p1;
        v.exp_flags = ef;  v.exp_row = er;   v.exp_col = ec;
        return v;
    endfunction

    // Overlay-correct pixel for a frame position; camera area gets random data.
    function automatic logic [23:0] cleanPixel(input int row, input int col);
        if (row < 5 && col < 5) return 24'hFF0000;
        if (row < 5 && col >= CW - 4 && col < CW) return 24'h00FF00;
        if (row >= CH - 4 && row < CH && col < 5) return 24'h0000FF;
        if (row >= CH || col >= CW) return 24'h000000;
        return 24'($urandom);
    endfunction

    function automatic void pushExpected(input int id, input vec_t v, input int when);
        exp_t e;
        e.id    = id;
        e.flags = v.exp_flags;
        e.ok    = (v.exp_flags == 5'd0);
        if (m_fcnt != '1) m_fcnt = m_fcnt + 1'b1;
        if (!e.ok && m_ecnt != '1) m_ecnt = m_ecnt + 1'b1;
        e.fcnt = m_fcnt;
        e.ecnt = m_ecnt;
`ifdef FMC_FIRST_ERR_CAPTURE_EN
        e.row = 13'(v.exp_row);
        e.col = 13'(v.exp_col);
`else
        e.row = 13'd0;
        e.col = 13'd0;
`endif
        e.cyc   = when;
        m_ok    = e.ok;
        m_flags = e.flags;
        sb.push_back(e);
    endfunction

    task automatic drivePixel(input logic sof, input logic valid, input logic [23:0] rgb);
        @(posedge iCLK);
        #1;
        i_sof   = sof;
        i_valid = valid;
        {i_VGA_R, i_VGA_G, i_VGA_B} = rgb;
    endtask

    task automatic applyStimulus(input int id, input vec_t v);
        int          total;
        int          idx;
        int          row;
        int          col;
        logic [23:0] rgb;
        if (v.stray) begin
            repeat (3) drivePixel(1'b1, 1'b0, 24'($urandom));
        end
        total = (v.short_len > 0) ? v.short_len : FRAME_PIX;
        idx = 0;
        while (idx < total) begin
            if (v.gap_pct > 0 && int'($urandom_range(99)) < v.gap_pct) begin
                drivePixel($urandom_range(1) == 1, 1'b0, 24'($urandom));
                continue;
            end
            row = idx / HA;
            col = idx % HA;
            rgb = cleanPixel(row, col);
            if (row == v.b0_row && col == v.b0_col) rgb = v.b0_rgb;
            if (row == v.b1_row && col == v.b1_col) rgb = v.b1_rgb;
            drivePixel(idx == 0, 1'b1, rgb);
            if (idx == 0 && have_pend) begin
                pushExpected(pend_id, pend_vec, cyc + 1);
                have_pend = 1'b0;
            end
            if (idx == total - 1 && v.short_len == 0) pushExpected(id, v, cyc + 1);
            idx++;
        end
        if (v.short_len > 0) begin
            pend_vec  = v;
            pend_id   = id;
            have_pend = 1'b1;
        end else begin
            drivePixel(1'b0, 1'b0, 24'h0);
        end
    endtask

    // Scoreboard monitor: every done pulse must match the oldest expected frame result.
    always @(negedge iCLK) begin
        if (o_frame_done === 1'b1) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_miss++;
                $display("[TB] FAIL unexpected_done: got pulse at cycle %0d, expected none", cyc);
            end else begin
                mon_e = sb.pop_front();
                checkOutput($sformatf("v%0d_done_cycle", mon_e.id), cyc, mon_e.cyc);
                checkOutput($sformatf("v%0d_flags", mon_e.id), o_err_flags, mon_e.flags);
                checkOutput($sformatf("v%0d_ok", mon_e.id), o_frame_ok, mon_e.ok);
                checkOutput($sformatf("v%0d_frame_cnt", mon_e.id), o_frame_cnt, mon_e.fcnt);
                checkOutput($sformatf("v%0d_err_cnt", mon_e.id), o_err_cnt, mon_e.ecnt);
                checkOutput($sformatf("v%0d_first_row", mon_e.id), o_first_err_row, mon_e.row);
                checkOutput($sformatf("v%0d_first_col", mon_e.id), o_first_err_col, mon_e.col);
            end
        end
    end

    // Watchdog so a stuck run still ends with a visible failure.
    initial begin
        #3000000;
        $display("[TB] FAIL watchdog: got no completion, expected finish before timeout");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main test sequence.
    initial begin
        vec_t vecs[NVEC];

        iRST    = 1'b1;
        i_sof   = 1'b0;
        i_valid = 1'b0;
        {i_VGA_R, i_VGA_G, i_VGA_B} = 24'h0;

        vecs[0]  = mkVec(0,   0,  0, -1, 0, 24'h0,       -1, 0, 24'h0,       5'b00000, 0, 0);
        vecs[1]  = mkVec(0,   0,  0,  2, 2, 24'hFF0100,  -1, 0, 24'h0,       5'b00001, 2, 2);
        vecs[2]  = mkVec(0,   0,  0, 15, 31, 24'h000001,  4, 24, 24'h00FE00, 5'b01010, 4, 24);
        vecs[3]  = mkVec(100, 0,  0, -1, 0, 24'h0,       -1, 0, 24'h0,       5'b10000, 3, 4);
        vecs[4]  = mkVec(0,   0,  0, -1, 0, 24'h0,       -1, 0, 24'h0,       5'b00000, 0, 0);
        vecs[5]  = mkVec(0,   30, 1, -1, 0, 24'h0,       -1, 0, 24'h0,       5'b00000, 0, 0);
        vecs[6]  = mkVec(0,   0,  0, 12, 3, 24'h0000FE,  -1, 0, 24'h0,       5'b00100, 12, 3);
        vecs[7]  = mkVec(0,   0,  0,  5, 28, 24'h010000, 14, 10, 24'h000100, 5'b01000, 5, 28);
        vecs[8]  = mkVec(0,   0,  0,  4, 4, 24'h000000,   9, 0, 24'hFFFFFF,  5'b00001, 4, 4);
        vecs[9]  = mkVec(0,   0,  0,  0, 20, 24'hFFFFFF,  5, 22, 24'hFFFFFF, 5'b00000, 0, 0);
        vecs[10] = mkVec(0,   0,  0, 10, 5, 24'hFFFFFF,  13, 24, 24'hFFFFFF, 5'b00000, 0, 0);
        vecs[11] = mkVec(40,  20, 0,  1, 1, 24'h000000,  -1, 0, 24'h0,       5'b10001, 1, 1);
        vecs[12] = mkVec(1,   0,  0, -1, 0, 24'h0,       -1, 0, 24'h0,       5'b10000, 0, 1);
        vecs[13] = mkVec(0,   20, 0, 13, 25, 24'h0000FF, -1, 0, 24'h0,       5'b01000, 13, 25);
        vecs[14] = mkVec(0,   0,  0, -1, 0, 24'h0,       -1, 0, 24'h0,       5'b00000, 0, 0);

        repeat (3) @(posedge iCLK);
        #1;
        checkOutput("reset_done", o_frame_done, 0);
        checkOutput("reset_ok", o_frame_ok, 0);
        checkOutput("reset_flags", o_err_flags, 0);
        checkOutput("reset_frame_cnt", o_frame_cnt, 0);
        checkOutput("reset_err_cnt", o_err_cnt, 0);
        checkOutput("reset_first_row", o_first_err_row, 0);
        checkOutput("reset_first_col", o_first_err_col, 0);
        iRST = 1'b0;

        for (int i = 0; i < NVEC; i++) applyStimulus(i, vecs[i]);

        repeat (20) drivePixel(1'b0, 1'b0, 24'h0);
        checkOutput("hold_done", o_frame_done, 0);
        checkOutput("hold_ok", o_frame_ok, m_ok);
        checkOutput("hold_flags", o_err_flags, m_flags);
        checkOutput("hold_frame_cnt", o_frame_cnt, m_fcnt);
        checkOutput("hold_err_cnt", o_err_cnt, m_ecnt);

        for (int i = 0; i < 200; i++) drivePixel(i == 0, 1'b1, cleanPixel(i / HA, i % HA));
        @(posedge iCLK);
        #1;
        iRST    = 1'b1;
        i_sof   = 1'b0;
        i_valid = 1'b0;
        @(posedge iCLK);
        #1;
        checkOutput("midreset_frame_cnt", o_frame_cnt, 0);
        checkOutput("midreset_err_cnt", o_err_cnt, 0);
        checkOutput("midreset_ok", o_frame_ok, 0);
        checkOutput("midreset_flags", o_err_flags, 0);
        iRST   = 1'b0;
        m_fcnt = '0;
        m_ecnt = '0;
        applyStimulus(100, vecs[0]);

        for (int i = 0; i < 16; i++) applyStimulus(200 + i, vecs[1]);

        for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge iCLK);
        checkOutput("scoreboard_drain", sb.size(), 0);
        #1;
        checkOutput("sat_frame_cnt", o_frame_cnt, 4'hF);
        checkOutput("sat_err_cnt", o_err_cnt, 4'hF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
